// File: rtl/alu_flag_stage.sv
// alu_flag_stage: execute stage producing a data result plus N/V/Z flag updates
// for a 3-bit flag register (bit0 N, bit1 V, bit2 Z). Arithmetic and logic ops
// complete in one cycle; shifts and rotates iterate one bit per cycle.
// Build option: define ALU_SAT_EN to make ADD/SUB saturate on signed overflow;
// without it ADD/SUB wrap modulo 2^WIDTH.
module alu_flag_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flag_wen,
  output logic [2:0]       flag_val
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [SH_W-1:0]  cnt;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] arith_res;
  logic [WIDTH-1:0] imm_res;
  logic             imm_v;
  logic             is_shift;
  logic [SH_W-1:0]  k;
  logic [WIDTH-1:0] step_res;
  logic [2:0]       mask;

  // Single-cycle result for the operation presented at the input
  always_comb begin
    b_eff     = (op == OP_SUB) ? ~b : b;
    sum       = a + b_eff + WIDTH'(op == OP_SUB);
    ovf       = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    arith_res = sum;
`ifdef ALU_SAT_EN
    if (ovf) arith_res = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
    k        = b[SH_W-1:0];
    is_shift = (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    imm_v    = 1'b0;
    imm_res  = a;
    case (op)
      OP_ADD, OP_SUB: begin
        imm_res = arith_res;
        imm_v   = ovf;
      end
      OP_AND:  imm_res = a & b;
      OP_XOR:  imm_res = a ^ b;
      OP_PASS: imm_res = b;
      default: imm_res = a;
    endcase
  end

  // One-bit step of the shift/rotate accumulator and flag write mask of the held op
  always_comb begin
    step_res = result;
    mask     = 3'b100;
    case (op_q)
      OP_SLL:  step_res = {result[WIDTH-2:0], 1'b0};
      OP_SRA:  step_res = {result[WIDTH-1], result[WIDTH-1:1]};
      OP_ROR:  step_res = {result[0], result[WIDTH-1:1]};
      default: step_res = result;
    endcase
    case (op_q)
      OP_ADD, OP_SUB: mask = 3'b111;
      OP_PASS:        mask = 3'b000;
      default:        mask = 3'b100;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign flag_wen = (out_valid && out_ready) ? mask : 3'b000;

  // Control FSM with registered result, flags and valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      cnt       <= '0;
      result    <= '0;
      flag_val  <= 3'b000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            if (is_shift && (k != '0)) begin
              result <= a;
              cnt    <= k;
              state  <= SHIFT;
            end else begin
              result    <= imm_res;
              flag_val  <= {(imm_res == '0), imm_v, imm_res[WIDTH-1]};
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          result <= step_res;
          cnt    <= cnt - SH_W'(1);
          if (cnt == SH_W'(1)) begin
            flag_val  <= {(step_res == '0), 1'b0, step_res[WIDTH-1]};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Randomized self-checking bench for alu_flag_stage against an arithmetic reference model.
module tb_alu_flag_stage;

  localparam int unsigned W  = 16;
  localparam int unsigned KW = 4;
  localparam int MAXS = (2 ** (W - 1)) - 1;
  localparam int MINS = -(2 ** (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [2:0]   flag_wen;
  logic [2:0]   flag_val;

  int checks = 0;
  int errors = 0;

  alu_flag_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_wen(flag_wen), .flag_val(flag_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic and whole-word shifts
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] res, output logic [2:0] mask,
                                output logic [2:0] fv);
    int sx, sy, s, k;
    bit ov;
    logic [2*W-1:0] dbl;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    k   = int'(y[KW-1:0]);
    ov  = 1'b0;
    s   = 0;
    res = x;
    mask = 3'b100;
    case (o)
      3'd0, 3'd1: begin
        s    = (o == 3'd0) ? sx + sy : sx - sy;
        ov   = (s > MAXS) || (s < MINS);
        res  = W'(s);
`ifdef ALU_SAT_EN
        if (ov) res = (s > 0) ? W'(MAXS) : W'(MINS);
`endif
        mask = 3'b111;
      end
      3'd2: res = x & y;
      3'd3: res = x ^ y;
      3'd4: res = x << k;
      3'd5: res = W'($signed(x) >>> k);
      3'd6: begin
        dbl = {x, x} >> k;
        res = dbl[W-1:0];
      end
      default: begin
        res  = y;
        mask = 3'b000;
      end
    endcase
    fv = {(res == '0), ov, res[W-1]};
  endfunction

  // Issue one op, track latency, optionally stall, then release and verify the handoff
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int stall, input bit rdy_early);
    logic [W-1:0] er;
    logic [2:0]   em, ef;
    int exp_lat, cyc;
    bit seen;
    model(o, x, y, er, em, ef);
    exp_lat = ((o == 3'd4) || (o == 3'd5) || (o == 3'd6)) ? 1 + int'(y[KW-1:0]) : 1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = rdy_early;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      op = 3'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
      if (out_valid) seen = 1'b1;
      else begin
        check("in_ready_busy", 32'(in_ready), 32'd0);
        check("wen_busy", 32'(flag_wen), 32'd0);
      end
    end
    if (!seen) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      return;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", 32'(result), 32'(er));
      check("stall_wen", 32'(flag_wen), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      a = W'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("out_valid", 32'(out_valid), 32'd1);
    check("result", 32'(result), 32'(er));
    check("flag_wen", 32'(flag_wen), 32'(em));
    check("flag_val", 32'(flag_val & em), 32'(ef & em));
    @(negedge clk);
    check("valid_after", 32'(out_valid), 32'd0);
    check("wen_after", 32'(flag_wen), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flag_val", 32'(flag_val), 32'd0);
    check("rst_flag_wen", 32'(flag_wen), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_op(3'd0, 16'h7FFF, 16'h0001, 0, 1'b1);
`ifdef ALU_SAT_EN
    check("add_ovf_result", 32'(result), 32'h7FFF);
`endif
    run_op(3'd1, 16'h1234, 16'h1234, 0, 1'b1);
    run_op(3'd5, 16'h8000, 16'd15, 2, 1'b0);
    run_op(3'd4, 16'hFFFF, 16'd15, 0, 1'b1);
    run_op(3'd3, 16'hA5A5, 16'hA5A5, 5, 1'b0);

    // Reset in the middle of a rotate discards it without any flag write
    in_valid  = 1'b1;
    op        = 3'd6;
    a         = 16'h0001;
    b         = 16'd4;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_wen", 32'(flag_wen), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("midrst_no_valid", 32'(out_valid), 32'd0);
      check("midrst_no_wen", 32'(flag_wen), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;

    run_op(3'd7, 16'h0000, 16'h0000, 0, 1'b1);
    run_op(3'd6, 16'h0001, 16'h0000, 0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      logic [2:0]   ro;
      logic [W-1:0] rx, ry;
      int st;
      bit re;
      ro = 3'($urandom);
      rx = W'($urandom);
      ry = W'($urandom);
      case ($urandom_range(0, 7))
        0: rx = 16'h7FFF;
        1: rx = 16'h8000;
        2: ry = rx;
        3: ry = 16'h8000;
        default: ;
      endcase
      st = $urandom_range(0, 3);
      re = (st == 0) ? 1'($urandom) : 1'b0;
      run_op(ro, rx, ry, st, re);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
